// File: rtl/can_frame_scheduler.sv
// CAN receive-path bus-state controller: integration, frame reception,
// error/overload frame hand-off and intermission tracking.
module can_frame_scheduler #(
    parameter int unsigned INTEG_BITS = 11,
    parameter int unsigned ITM_BITS   = 3,
    parameter int unsigned MAX_OVL    = 2,
    parameter int unsigned OE_TIMEOUT = 64
) (
    input  logic       SP,
    input  logic       reset,
    input  logic       RX,
    input  logic       F_ERR,
    input  logic       F_EOF,
    input  logic       F_OVRLD_REQ,
    input  logic       F_ITMSSw,
    output logic       F_OVRLD,
    output logic       OE_TYPE,
    output logic       DEC_EN,
    output logic       BUS_IDLE,
    output logic       F_SOF,
    output logic [1:0] OVL_CNT,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        INTEG   = 3'd0,
        IDLE    = 3'd1,
        RECEIVE = 3'd2,
        OE_ERR  = 3'd3,
        OE_OVL  = 3'd4,
        ITM     = 3'd5
    } state_t;

    localparam int unsigned IW = $clog2(INTEG_BITS + 1);
    localparam int unsigned TW = $clog2(ITM_BITS + 2);
    localparam int unsigned OW = $clog2(OE_TIMEOUT + 1);
    localparam logic [IW-1:0] INTEG_LAST = IW'(INTEG_BITS - 1);
    localparam logic [TW-1:0] ITM_LAST   = TW'(ITM_BITS);
    localparam logic [OW-1:0] OE_LAST    = OW'(OE_TIMEOUT - 1);
    localparam logic [1:0]    OVL_MAX    = 2'(MAX_OVL);

    state_t          state, next_state;
    logic [IW-1:0]   integ_cnt;
    logic [TW-1:0]   itm_cnt;
    logic [OW-1:0]   to_cnt;
    logic            f_ovrld_d, oe_type_d, dec_en_d, bus_idle_d, f_sof_d;
    logic [1:0]      ovl_d;
    logic            in_oe, next_oe;

    assign in_oe   = (state == OE_ERR) || (state == OE_OVL);
    assign next_oe = (next_state == OE_ERR) || (next_state == OE_OVL);
    assign STATE   = state;

    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            state     <= INTEG;
            integ_cnt <= '0;
            itm_cnt   <= '0;
            to_cnt    <= '0;
            F_OVRLD   <= 1'b1;
            OE_TYPE   <= 1'b0;
            DEC_EN    <= 1'b0;
            BUS_IDLE  <= 1'b0;
            F_SOF     <= 1'b0;
            OVL_CNT   <= '0;
        end else begin
            state     <= next_state;
            integ_cnt <= (state == INTEG && next_state == INTEG && RX) ? integ_cnt + IW'(1) : '0;
            // itm_cnt holds the number of the bit about to be sampled; it is 1 on ITM entry
            itm_cnt   <= (state == ITM) ? itm_cnt + TW'(1) : TW'(1);
            to_cnt    <= (in_oe && next_state == state) ? to_cnt + OW'(1) : '0;
            F_OVRLD   <= f_ovrld_d;
            OE_TYPE   <= oe_type_d;
            DEC_EN    <= dec_en_d;
            BUS_IDLE  <= bus_idle_d;
            F_SOF     <= f_sof_d;
            OVL_CNT   <= ovl_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INTEG:   if (RX && integ_cnt == INTEG_LAST) next_state = IDLE;
            IDLE:    if (!RX) next_state = RECEIVE;
            RECEIVE: begin
                if (F_ERR)
                    next_state = OE_ERR;
                else if (F_EOF)
                    next_state = (F_OVRLD_REQ && OVL_CNT < OVL_MAX) ? OE_OVL : ITM;
            end
            OE_ERR, OE_OVL: begin
                if (F_ITMSSw)
                    next_state = ITM;
                else if (to_cnt == OE_LAST)
                    next_state = INTEG;
            end
            ITM: begin
                if (!RX) begin
                    if (itm_cnt == ITM_LAST)
                        next_state = RECEIVE;
                    else
                        next_state = (OVL_CNT < OVL_MAX) ? OE_OVL : OE_ERR;
                end else if (itm_cnt == ITM_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = INTEG;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it
    always_comb begin
        f_ovrld_d  = !(next_oe && next_state != state);
        oe_type_d  = (next_state == OE_ERR);
        dec_en_d   = (next_state == RECEIVE);
        bus_idle_d = (next_state == IDLE);
        f_sof_d    = (next_state == RECEIVE) && (state != RECEIVE);
        ovl_d      = OVL_CNT;
        if (next_state == IDLE || next_state == RECEIVE)
            ovl_d = '0;
        else if (next_state == OE_OVL && state != OE_OVL && OVL_CNT < OVL_MAX)
            ovl_d = OVL_CNT + 2'd1;
    end
endmodule

// File: tb/tb_can_frame_scheduler.sv
// Directed self-checking bench for can_frame_scheduler.
module tb_can_frame_scheduler;
    logic       SP, reset, RX, F_ERR, F_EOF, F_OVRLD_REQ, F_ITMSSw;
    logic       F_OVRLD, OE_TYPE, DEC_EN, BUS_IDLE, F_SOF;
    logic [1:0] OVL_CNT;
    logic [2:0] STATE;
    logic [9:0] obs;
    int         checks = 0;
    int         errors = 0;

    can_frame_scheduler #(
        .INTEG_BITS(11),
        .ITM_BITS(3),
        .MAX_OVL(2),
        .OE_TIMEOUT(64)
    ) dut (
        .SP(SP), .reset(reset), .RX(RX), .F_ERR(F_ERR), .F_EOF(F_EOF),
        .F_OVRLD_REQ(F_OVRLD_REQ), .F_ITMSSw(F_ITMSSw), .F_OVRLD(F_OVRLD),
        .OE_TYPE(OE_TYPE), .DEC_EN(DEC_EN), .BUS_IDLE(BUS_IDLE), .F_SOF(F_SOF),
        .OVL_CNT(OVL_CNT), .STATE(STATE)
    );

    // obs = {STATE, F_OVRLD, OE_TYPE, DEC_EN, BUS_IDLE, F_SOF, OVL_CNT}
    assign obs = {STATE, F_OVRLD, OE_TYPE, DEC_EN, BUS_IDLE, F_SOF, OVL_CNT};

    initial SP = 1'b0;
    always #5 SP = ~SP;

    task automatic step;
        @(posedge SP);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b0; RX = 1'b0; F_ERR = 1'b0; F_EOF = 1'b0;
        F_OVRLD_REQ = 1'b0; F_ITMSSw = 1'b0;
        repeat (2) step();
        checks++;
        if (obs !== 10'b000_1_0_0_0_0_00) begin
            errors++; $display("FAIL reset_values: obs=%b expected=%b", obs, 10'b000_1_0_0_0_0_00);
        end
        reset = 1'b1;
    endtask

    task automatic test_integration;
        RX = 1'b1;
        repeat (10) step();
        checks++;
        if (obs !== 10'b000_1_0_0_0_0_00) begin
            errors++; $display("FAIL integ_10_bits: obs=%b expected=%b", obs, 10'b000_1_0_0_0_0_00);
        end
        step();
        checks++;
        if (obs !== 10'b001_1_0_0_1_0_00) begin
            errors++; $display("FAIL integ_11_bits: obs=%b expected=%b", obs, 10'b001_1_0_0_1_0_00);
        end
        reset = 1'b0; #2; reset = 1'b1;
        repeat (7) step();
        RX = 1'b0;
        step();
        RX = 1'b1;
        repeat (10) step();
        checks++;
        if (obs !== 10'b000_1_0_0_0_0_00) begin
            errors++; $display("FAIL integ_restart_hold: obs=%b expected=%b", obs, 10'b000_1_0_0_0_0_00);
        end
        step();
        checks++;
        if (obs !== 10'b001_1_0_0_1_0_00) begin
            errors++; $display("FAIL integ_restart_done: obs=%b expected=%b", obs, 10'b001_1_0_0_1_0_00);
        end
    endtask

    task automatic test_normal_frame;
        RX = 1'b0;
        step();
        checks++;
        if (obs !== 10'b010_1_0_1_0_1_00) begin
            errors++; $display("FAIL sof_entry: obs=%b expected=%b", obs, 10'b010_1_0_1_0_1_00);
        end
        RX = 1'b1;
        step();
        checks++;
        if (obs !== 10'b010_1_0_1_0_0_00) begin
            errors++; $display("FAIL sof_one_cycle: obs=%b expected=%b", obs, 10'b010_1_0_1_0_0_00);
        end
        F_EOF = 1'b1;
        step();
        F_EOF = 1'b0;
        checks++;
        if (obs !== 10'b101_1_0_0_0_0_00) begin
            errors++; $display("FAIL eof_to_itm: obs=%b expected=%b", obs, 10'b101_1_0_0_0_0_00);
        end
        repeat (2) step();
        checks++;
        if (obs !== 10'b101_1_0_0_0_0_00) begin
            errors++; $display("FAIL itm_hold: obs=%b expected=%b", obs, 10'b101_1_0_0_0_0_00);
        end
        step();
        checks++;
        if (obs !== 10'b001_1_0_0_1_0_00) begin
            errors++; $display("FAIL itm_to_idle: obs=%b expected=%b", obs, 10'b001_1_0_0_1_0_00);
        end
    endtask

    task automatic test_error_frame;
        RX = 1'b0;
        step();
        RX = 1'b1; F_ITMSSw = 1'b1;
        step();
        F_ITMSSw = 1'b0;
        checks++;
        if (obs !== 10'b010_1_0_1_0_0_00) begin
            errors++; $display("FAIL itmssw_ignored_rx: obs=%b expected=%b", obs, 10'b010_1_0_1_0_0_00);
        end
        F_ERR = 1'b1; F_EOF = 1'b1;
        step();
        F_ERR = 1'b0; F_EOF = 1'b0;
        checks++;
        if (obs !== 10'b011_0_1_0_0_0_00) begin
            errors++; $display("FAIL err_priority_entry: obs=%b expected=%b", obs, 10'b011_0_1_0_0_0_00);
        end
        step();
        checks++;
        if (obs !== 10'b011_1_1_0_0_0_00) begin
            errors++; $display("FAIL err_strobe_width: obs=%b expected=%b", obs, 10'b011_1_1_0_0_0_00);
        end
        repeat (18) step();
        F_ITMSSw = 1'b1;
        step();
        F_ITMSSw = 1'b0;
        checks++;
        if (obs !== 10'b101_1_0_0_0_0_00) begin
            errors++; $display("FAIL err_itmssw: obs=%b expected=%b", obs, 10'b101_1_0_0_0_0_00);
        end
        repeat (3) step();
        checks++;
        if (obs !== 10'b001_1_0_0_1_0_00) begin
            errors++; $display("FAIL err_back_idle: obs=%b expected=%b", obs, 10'b001_1_0_0_1_0_00);
        end
    endtask

    task automatic test_overload_limit;
        RX = 1'b0;
        step();
        RX = 1'b1; F_EOF = 1'b1; F_OVRLD_REQ = 1'b1;
        step();
        F_EOF = 1'b0; F_OVRLD_REQ = 1'b0;
        checks++;
        if (obs !== 10'b100_0_0_0_0_0_01) begin
            errors++; $display("FAIL ovl1_entry: obs=%b expected=%b", obs, 10'b100_0_0_0_0_0_01);
        end
        step();
        F_ITMSSw = 1'b1;
        step();
        F_ITMSSw = 1'b0;
        checks++;
        if (obs !== 10'b101_1_0_0_0_0_01) begin
            errors++; $display("FAIL ovl1_to_itm: obs=%b expected=%b", obs, 10'b101_1_0_0_0_0_01);
        end
        step();
        RX = 1'b0;
        step();
        RX = 1'b1;
        checks++;
        if (obs !== 10'b100_0_0_0_0_0_10) begin
            errors++; $display("FAIL ovl2_itm_bit2: obs=%b expected=%b", obs, 10'b100_0_0_0_0_0_10);
        end
        step();
        F_ITMSSw = 1'b1;
        step();
        F_ITMSSw = 1'b0;
        RX = 1'b0;
        step();
        RX = 1'b1;
        checks++;
        if (obs !== 10'b011_0_1_0_0_0_10) begin
            errors++; $display("FAIL ovl_limit_err: obs=%b expected=%b", obs, 10'b011_0_1_0_0_0_10);
        end
        F_ITMSSw = 1'b1;
        step();
        F_ITMSSw = 1'b0;
        checks++;
        if (obs !== 10'b101_1_0_0_0_0_10) begin
            errors++; $display("FAIL ovl_err_to_itm: obs=%b expected=%b", obs, 10'b101_1_0_0_0_0_10);
        end
    endtask

    task automatic test_late_sof;
        RX = 1'b1;
        repeat (2) step();
        RX = 1'b0;
        step();
        RX = 1'b1;
        checks++;
        if (obs !== 10'b010_1_0_1_0_1_00) begin
            errors++; $display("FAIL late_sof: obs=%b expected=%b", obs, 10'b010_1_0_1_0_1_00);
        end
    endtask

    task automatic test_timeout;
        F_ERR = 1'b1;
        step();
        F_ERR = 1'b0;
        step();
        F_ERR = 1'b1;
        step();
        F_ERR = 1'b0;
        checks++;
        if (obs !== 10'b011_1_1_0_0_0_00) begin
            errors++; $display("FAIL ferr_ignored_oe: obs=%b expected=%b", obs, 10'b011_1_1_0_0_0_00);
        end
        repeat (61) step();
        checks++;
        if (obs !== 10'b011_1_1_0_0_0_00) begin
            errors++; $display("FAIL timeout_63: obs=%b expected=%b", obs, 10'b011_1_1_0_0_0_00);
        end
        step();
        checks++;
        if (obs !== 10'b000_1_0_0_0_0_00) begin
            errors++; $display("FAIL timeout_abort: obs=%b expected=%b", obs, 10'b000_1_0_0_0_0_00);
        end
        repeat (11) step();
        RX = 1'b0;
        step();
        RX = 1'b1; F_ERR = 1'b1;
        step();
        F_ERR = 1'b0;
        repeat (63) step();
        F_ITMSSw = 1'b1;
        step();
        F_ITMSSw = 1'b0;
        checks++;
        if (obs !== 10'b101_1_0_0_0_0_00) begin
            errors++; $display("FAIL itmssw_beats_timeout: obs=%b expected=%b", obs, 10'b101_1_0_0_0_0_00);
        end
    endtask

    task automatic test_async_reset;
        repeat (3) step();
        RX = 1'b0;
        step();
        RX = 1'b1;
        step();
        checks++;
        if (obs !== 10'b010_1_0_1_0_0_00) begin
            errors++; $display("FAIL pre_reset_receive: obs=%b expected=%b", obs, 10'b010_1_0_1_0_0_00);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b000_1_0_0_0_0_00) begin
            errors++; $display("FAIL async_reset: obs=%b expected=%b", obs, 10'b000_1_0_0_0_0_00);
        end
        #1 reset = 1'b1;
        step();
        checks++;
        if (obs !== 10'b000_1_0_0_0_0_00) begin
            errors++; $display("FAIL post_reset_integ: obs=%b expected=%b", obs, 10'b000_1_0_0_0_0_00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_integration();
        test_normal_frame();
        test_error_frame();
        test_overload_limit();
        test_late_sof();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
